// File: rtl/timer_alarm_pkg.sv
// -----------------------------------------------------------------------------
// timer_alarm_pkg
// Shared definitions for the timer alarm/compare unit: register byte offsets,
// CTRL/STATUS bit positions, the alarm state encoding and the default
// nanosecond wrap value of the time base.
// -----------------------------------------------------------------------------
package timer_alarm_pkg;

    // Nanoseconds per second of the timer time base.
    localparam int unsigned NS_PER_SEC_DEFAULT = 1_000_000_000;

    // Register byte offsets.
    localparam logic [4:0] ADDR_CMP_SEC_LO = 5'h00;
    localparam logic [4:0] ADDR_CMP_SEC_HI = 5'h04;
    localparam logic [4:0] ADDR_CMP_NSEC   = 5'h08;
    localparam logic [4:0] ADDR_PERIOD     = 5'h0C;
    localparam logic [4:0] ADDR_CTRL       = 5'h10;
    localparam logic [4:0] ADDR_STATUS     = 5'h14;

    // CTRL bit positions.
    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // STATUS bit positions. The 2-bit state code sits above the flag bits.
    localparam int STAT_PENDING   = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_ARMED     = 2;
    localparam int STAT_STATE_LSB = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } state_t;

endpackage

// File: rtl/timer_alarm_ns_time_add.sv
// -----------------------------------------------------------------------------
// ns_time_add
// Combinational {sec, nsec} + period_ns with carry into seconds. The period
// is expected to be below NS_PER_SEC, so at most one carry is produced.
// Seconds wrap modulo 2^64.
// Ports:
//   i_sec    [63:0]  base seconds
//   i_nsec   [31:0]  base nanoseconds
//   i_period [31:0]  increment in nanoseconds
//   o_sec    [63:0]  result seconds
//   o_nsec   [31:0]  result nanoseconds
// -----------------------------------------------------------------------------
module ns_time_add #(
    parameter int unsigned NS_PER_SEC = 1_000_000_000
) (
    input  logic [63:0] i_sec,
    input  logic [31:0] i_nsec,
    input  logic [31:0] i_period,
    output logic [63:0] o_sec,
    output logic [31:0] o_nsec
);

    localparam logic [32:0] NS_WRAP_33 = 33'(NS_PER_SEC);
    localparam logic [31:0] NS_WRAP_32 = 32'(NS_PER_SEC);

    logic [32:0] w_sum;

    // 33-bit sum so an out-of-range nsec plus period cannot silently wrap.
    assign w_sum = {1'b0, i_nsec} + {1'b0, i_period};

    always_comb begin
        o_sec  = i_sec;
        o_nsec = w_sum[31:0];
        if (w_sum >= NS_WRAP_33) begin
            // Difference is taken modulo 2^32; the true result fits there.
            o_nsec = w_sum[31:0] - NS_WRAP_32;
            o_sec  = i_sec + 64'd1;
        end
    end

endmodule

// File: rtl/timer_alarm.sv
// -----------------------------------------------------------------------------
// timer_alarm
// Compare/alarm unit fed by the timer's live {seconds, nanoseconds} count.
// Raises a level interrupt when the count reaches a programmed deadline; in
// periodic mode the deadline is advanced by PERIOD ns on every match.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_sec[63:0]           timer seconds
//   i_nsec[31:0]          timer nanoseconds
//   i_addr[4:0]           register byte address
//   i_stb, i_we           bus strobe / write enable
//   i_dat_w[31:0]         write data
//   o_dat_r[31:0]         read data (combinational decode)
//   o_ack                 bus acknowledge (mirrors i_stb)
//   o_irq                 PENDING & IRQ_EN
// STATUS read layout: bit0 PENDING, bit1 OVERRUN, bit2 ARMED, bits[4:3] state.
// -----------------------------------------------------------------------------
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int unsigned NS_PER_SEC = NS_PER_SEC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [63:0] i_sec,
    input  logic [31:0] i_nsec,
    input  logic [4:0]  i_addr,
    input  logic        i_stb,
    input  logic        i_we,
    input  logic [31:0] i_dat_w,
    output logic [31:0] o_dat_r,
    output logic        o_ack,
    output logic        o_irq
);

    localparam logic [31:0] NS_WRAP = 32'(NS_PER_SEC);

    logic [63:0] r_cmp_sec;
    logic [31:0] r_cmp_nsec;
    logic [31:0] r_period;
    logic [2:0]  r_ctrl;
    logic        r_pending;
    logic        r_overrun;
    state_t      r_state;
    state_t      w_state_next;

    logic        w_wr;
    logic        w_wr_ctrl;
    logic        w_wr_cmp;
    logic        w_match;
    logic        w_periodic;
    logic        w_reload;
    logic [63:0] w_rl_sec;
    logic [31:0] w_rl_nsec;
    logic [31:0] w_status;

    assign w_wr      = i_stb & i_we;
    assign w_wr_ctrl = w_wr && (i_addr == ADDR_CTRL);
    assign w_wr_cmp  = w_wr && ((i_addr == ADDR_CMP_SEC_LO) ||
                                (i_addr == ADDR_CMP_SEC_HI) ||
                                (i_addr == ADDR_CMP_NSEC));

    // Only an armed alarm compares; the deadline is the registered value.
    assign w_match    = (r_state == ST_ARMED) &&
                        ({i_sec, i_nsec} >= {r_cmp_sec, r_cmp_nsec});
    // PERIOD = 0 degenerates to one-shot behaviour.
    assign w_periodic = r_ctrl[CTRL_PERIODIC] && (r_period != 32'd0);
    // A bus write to any compare register overrides the automatic reload.
    assign w_reload   = w_match && w_periodic && !w_wr_cmp;

    ns_time_add #(
        .NS_PER_SEC (NS_PER_SEC)
    ) u_reload_add (
        .i_sec    (r_cmp_sec),
        .i_nsec   (r_cmp_nsec),
        .i_period (r_period),
        .o_sec    (w_rl_sec),
        .o_nsec   (w_rl_nsec)
    );

    // ---------------- state machine ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ARMED: begin
                if (w_match && !w_periodic) begin
                    w_state_next = ST_FIRED;
                end
            end
            default: begin
                w_state_next = r_state;
            end
        endcase
        // A CTRL write decides the state outright, from any state.
        if (w_wr_ctrl) begin
            w_state_next = i_dat_w[CTRL_EN] ? ST_ARMED : ST_IDLE;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cmp_sec  <= '0;
            r_cmp_nsec <= '0;
            r_period   <= '0;
            r_ctrl     <= '0;
            r_pending  <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (w_reload) begin
                r_cmp_sec  <= w_rl_sec;
                r_cmp_nsec <= w_rl_nsec;
            end
            if (w_wr) begin
                case (i_addr)
                    ADDR_CMP_SEC_LO: r_cmp_sec[31:0]  <= i_dat_w;
                    ADDR_CMP_SEC_HI: r_cmp_sec[63:32] <= i_dat_w;
                    ADDR_CMP_NSEC:   r_cmp_nsec       <= i_dat_w;
                    ADDR_PERIOD:     r_period <= (i_dat_w >= NS_WRAP) ?
                                                 (NS_WRAP - 32'd1) : i_dat_w;
                    ADDR_CTRL:       r_ctrl   <= i_dat_w[2:0];
                    ADDR_STATUS: begin
                        if (i_dat_w[STAT_PENDING]) r_pending <= 1'b0;
                        if (i_dat_w[STAT_OVERRUN]) r_overrun <= 1'b0;
                    end
                    default: ;
                endcase
            end
            // Placed after the W1C so a coincident match keeps the flags set.
            if (w_match) begin
                r_pending <= 1'b1;
                if (r_pending) begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    // ---------------- bus read / outputs ----------------
    always_comb begin
        w_status = '0;
        w_status[STAT_PENDING] = r_pending;
        w_status[STAT_OVERRUN] = r_overrun;
        w_status[STAT_ARMED]   = (r_state == ST_ARMED);
        w_status[STAT_STATE_LSB +: 2] = r_state;
    end

    always_comb begin
        o_dat_r = '0;
        case (i_addr)
            ADDR_CMP_SEC_LO: o_dat_r = r_cmp_sec[31:0];
            ADDR_CMP_SEC_HI: o_dat_r = r_cmp_sec[63:32];
            ADDR_CMP_NSEC:   o_dat_r = r_cmp_nsec;
            ADDR_PERIOD:     o_dat_r = r_period;
            ADDR_CTRL:       o_dat_r = {29'd0, r_ctrl};
            ADDR_STATUS:     o_dat_r = w_status;
            default:         o_dat_r = '0;
        endcase
    end

    assign o_ack = i_stb;
    assign o_irq = r_pending & r_ctrl[CTRL_IRQ_EN];

endmodule

// File: tb/tb_timer_alarm.sv
// -----------------------------------------------------------------------------
// tb_timer_alarm
// Self-checking bench for timer_alarm. Expected read values and event times
// are queued when the stimulus is applied and popped when the DUT output is
// sampled. STATUS constants: bit0 PENDING, bit1 OVERRUN, bit2 ARMED,
// bits[4:3] state (0 IDLE, 1 ARMED, 2 FIRED).
// -----------------------------------------------------------------------------
module tb_timer_alarm;
    import timer_alarm_pkg::*;

    localparam int unsigned NS = 1_000_000_000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [63:0] i_sec = '0;
    logic [31:0] i_nsec = '0;
    logic [4:0]  i_addr = '0;
    logic        i_stb = 1'b0;
    logic        i_we = 1'b0;
    logic [31:0] i_dat_w = '0;
    logic [31:0] o_dat_r;
    logic        o_ack;
    logic        o_irq;

    timer_alarm #(.NS_PER_SEC(NS)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_sec   (i_sec),
        .i_nsec  (i_nsec),
        .i_addr  (i_addr),
        .i_stb   (i_stb),
        .i_we    (i_we),
        .i_dat_w (i_dat_w),
        .o_dat_r (o_dat_r),
        .o_ack   (o_ack),
        .o_irq   (o_irq)
    );

    always #10 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    logic [63:0] tsec  = '0;
    logic [31:0] tnsec = '0;
    bit          ramp  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // One clock: inputs change 2 ns after the edge, outputs settle 1 ns later.
    task automatic cyc();
        @(posedge i_clk);
        #2;
        if (ramp) tnsec = tnsec + 32'd40;
        i_sec  = tsec;
        i_nsec = tnsec;
        #1;
    endtask

    task automatic set_time(input logic [63:0] s, input logic [31:0] ns);
        tsec = s; tnsec = ns;
        i_sec = s; i_nsec = ns;
        #1;
    endtask

    task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
        i_addr = addr; i_dat_w = data; i_stb = 1'b1; i_we = 1'b1;
        cyc();
        i_stb = 1'b0; i_we = 1'b0;
    endtask

    task automatic expect_read(input logic [4:0] addr, input logic [31:0] exp,
                               input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        i_addr = addr; i_stb = 1'b1; i_we = 1'b0;
        #1;
        check_val({tag, "_ack"}, {31'd0, o_ack}, 32'd1);
        check_val(tag_q.pop_front(), o_dat_r, exp_q.pop_front());
        i_stb = 1'b0;
    endtask

    task automatic do_reset();
        ramp = 1'b0;
        set_time(64'd0, 32'd0);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
    endtask

    // Waits a bounded number of cycles for o_irq; a timeout is a failure.
    task automatic wait_irq(input string tag, input int max_cyc);
        bit seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            cyc();
            if (o_irq) seen = 1'b1;
        end
        if (!seen) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset();
        expect_read(ADDR_CMP_SEC_LO, 32'd0, "rst_cmp_lo");
        expect_read(ADDR_CMP_SEC_HI, 32'd0, "rst_cmp_hi");
        expect_read(ADDR_CMP_NSEC,   32'd0, "rst_cmp_ns");
        expect_read(ADDR_PERIOD,     32'd0, "rst_period");
        expect_read(ADDR_CTRL,       32'd0, "rst_ctrl");
        expect_read(ADDR_STATUS,     32'd0, "rst_status");
        expect_read(5'h18,           32'd0, "unmapped_18");
        check_val("rst_irq", {31'd0, o_irq}, 32'd0);

        // ---------------- PERIOD clamp ----------------
        bus_write(ADDR_PERIOD, 32'hFFFF_FFFF);
        expect_read(ADDR_PERIOD, NS - 1, "clamp_max");
        bus_write(ADDR_PERIOD, NS);
        expect_read(ADDR_PERIOD, NS - 1, "clamp_ns");
        bus_write(ADDR_PERIOD, NS - 1);
        expect_read(ADDR_PERIOD, NS - 1, "clamp_nsm1");

        // ---------------- one-shot ----------------
        do_reset();
        bus_write(ADDR_CMP_NSEC, 32'd500);
        bus_write(ADDR_CTRL, 32'b101);
        // First 40 ns step at or past 500 is 520; irq follows that edge.
        exp_q.push_back(32'd520);
        tag_q.push_back("oneshot_match_ns");
        ramp = 1'b1;
        wait_irq("oneshot", 40);
        check_val(tag_q.pop_front(), tnsec - 32'd40, exp_q.pop_front());
        ramp = 1'b0;
        expect_read(ADDR_STATUS, 32'h11, "oneshot_status");
        bus_write(ADDR_STATUS, 32'h1);
        check_val("oneshot_w1c_irq", {31'd0, o_irq}, 32'd0);
        expect_read(ADDR_STATUS, 32'h10, "oneshot_w1c_status");

        // ---------------- periodic with seconds carry ----------------
        do_reset();
        bus_write(ADDR_CMP_SEC_LO, 32'd2);
        bus_write(ADDR_CMP_NSEC, 32'd999_999_900);
        bus_write(ADDR_PERIOD, 32'd200);
        bus_write(ADDR_CTRL, 32'b111);
        set_time(64'd2, 32'd999_999_950);
        cyc();
        cyc();
        expect_read(ADDR_CMP_SEC_LO, 32'd3,   "carry_sec_lo");
        expect_read(ADDR_CMP_SEC_HI, 32'd0,   "carry_sec_hi");
        expect_read(ADDR_CMP_NSEC,   32'd100, "carry_nsec");
        expect_read(ADDR_STATUS,     32'h0D,  "carry_status");
        check_val("carry_irq", {31'd0, o_irq}, 32'd1);

        // ---------------- seconds wrap modulo 2^64 ----------------
        do_reset();
        bus_write(ADDR_CMP_SEC_LO, 32'hFFFF_FFFF);
        bus_write(ADDR_CMP_SEC_HI, 32'hFFFF_FFFF);
        bus_write(ADDR_CMP_NSEC, 32'd999_999_900);
        bus_write(ADDR_PERIOD, 32'd200);
        bus_write(ADDR_CTRL, 32'b111);
        set_time(64'hFFFF_FFFF_FFFF_FFFF, 32'd999_999_950);
        cyc();
        expect_read(ADDR_CMP_SEC_LO, 32'd0,   "wrap_sec_lo");
        expect_read(ADDR_CMP_SEC_HI, 32'd0,   "wrap_sec_hi");
        expect_read(ADDR_CMP_NSEC,   32'd100, "wrap_nsec");

        // ---------------- overrun ----------------
        do_reset();
        bus_write(ADDR_CMP_NSEC, 32'd100);
        bus_write(ADDR_PERIOD, 32'd40);
        bus_write(ADDR_CTRL, 32'b111);
        ramp = 1'b1;
        wait_irq("overrun", 40);
        expect_read(ADDR_STATUS, 32'h0D, "overrun_first");
        cyc();
        expect_read(ADDR_STATUS, 32'h0F, "overrun_second");
        ramp = 1'b0;

        // ---------------- PERIOD = 0 behaves as one-shot ----------------
        do_reset();
        bus_write(ADDR_CMP_NSEC, 32'd100);
        bus_write(ADDR_CTRL, 32'b111);
        set_time(64'd0, 32'd200);
        cyc();
        expect_read(ADDR_STATUS,   32'h11,  "period0_status");
        expect_read(ADDR_CMP_NSEC, 32'd100, "period0_no_reload");

        // ---------------- simultaneous match and W1C; disable ----------------
        do_reset();
        bus_write(ADDR_CMP_NSEC, 32'd100);
        bus_write(ADDR_PERIOD, 32'd40);
        bus_write(ADDR_CTRL, 32'b111);
        set_time(64'd0, 32'd1000);
        cyc();
        bus_write(ADDR_STATUS, 32'h1);
        expect_read(ADDR_STATUS, 32'h0F, "w1c_vs_match");
        bus_write(ADDR_CTRL, 32'b110);
        expect_read(ADDR_STATUS, 32'h03, "disable_idle");
        bus_write(ADDR_STATUS, 32'h3);
        cyc(); cyc(); cyc();
        expect_read(ADDR_STATUS, 32'h00, "disable_no_match");
        check_val("disable_irq", {31'd0, o_irq}, 32'd0);

        // ---------------- reset while armed with pending ----------------
        do_reset();
        bus_write(ADDR_CMP_NSEC, 32'd100);
        bus_write(ADDR_CTRL, 32'b101);
        set_time(64'd0, 32'd200);
        cyc();
        check_val("midrst_irq_before", {31'd0, o_irq}, 32'd1);
        i_rst = 1'b1;
        cyc();
        i_rst = 1'b0;
        check_val("midrst_irq_after", {31'd0, o_irq}, 32'd0);
        expect_read(ADDR_STATUS,   32'd0, "midrst_status");
        expect_read(ADDR_CMP_NSEC, 32'd0, "midrst_cmp_ns");
        expect_read(ADDR_CTRL,     32'd0, "midrst_ctrl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
